uart_periph: RTL and testbench

UART_PERIPH -- requirements
Module: uart_periph

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_if.sv | 17 +
 rtl/uart_rx_core.sv | 109 ++++++++++
 rtl/uart_periph.sv | 213 +++++++++++++++++++++
 tb/tb_uart_periph.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register offsets, CON bit indices and FSM encodings for the UART peripheral
package uart_pkg;

    // Byte offsets of the registers relative to BASE_ADDR
    localparam logic [31:0] TXD_OFS = 32'h0000_0000;
    localparam logic [31:0] RXD_OFS = 32'h0000_0004;
    localparam logic [31:0] CON_OFS = 32'h0000_0008;

    // CON register bit positions
    localparam int CON_TX_IRQ_EN  = 0;
    localparam int CON_RX_IRQ_EN  = 1;
    localparam int CON_TX_DONE    = 2;
    localparam int CON_RX_VALID   = 3;
    localparam int CON_TX_BUSY    = 4;
    localparam int CON_RX_OVERRUN = 5;
    localparam int CON_FRAME_ERR  = 6;

    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

endpackage

// File: rtl/uart_if.sv
// rtl/uart_if.sv - CPU-side register bus of the UART peripheral
// rd/wr    : read / write strobes from the CPU memory stage
// addr     : full 32-bit byte address
// wdata    : write data
// rdata    : combinational read data
// irqout   : registered level interrupt request
interface uart_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irqout;

    modport master (output rd, wr, addr, wdata, input rdata, irqout);
    modport slave  (input rd, wr, addr, wdata, output rdata, irqout);
endinterface

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver: input synchronizer, RX FSM, byte/valid/frame-error outputs
// clk, reset     : clock, asynchronous active-low reset
// rxd_async      : raw serial input
// rx_byte        : last assembled byte (stable while rx_byte_valid is high)
// rx_byte_valid  : one-cycle pulse, good stop bit seen
// rx_frame_err   : one-cycle pulse, stop bit sampled low
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd_async,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       rx_frame_err
);
    localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]  sync_q, sync_d;
    logic        prev_q, prev_d;
    rx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        rxd_s;

    assign rxd_s  = sync_q[1];
    assign sync_d = {sync_q[0], rxd_async};
    // Previous synchronized level, so only a true high-to-low transition starts a frame
    assign prev_d = rxd_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= R_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        rx_byte_valid = 1'b0;
        rx_frame_err  = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (prev_q && !rxd_s) begin
                    state_d = R_START;
                    cnt_d   = '0;
                end
            end
            R_START: begin
                // Half-bit re-sample: a line back high is a glitch, not a start bit
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxd_s ? R_IDLE : R_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            R_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = R_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            R_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    state_d = R_IDLE;
                    if (rxd_s) begin
                        rx_byte_valid = 1'b1;
                    end else begin
                        rx_frame_err = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    assign rx_byte = shift_q;

endmodule

// File: rtl/uart_periph.sv
// rtl/uart_periph.sv - memory-mapped UART with TXD/RXD/CON registers and level interrupt
// clk, reset     : clock, asynchronous active-low reset
// bus            : CPU register bus (rd, wr, addr, wdata, rdata, irqout)
// PC_Uart_rxd    : serial input, asynchronous to clk
// PC_Uart_txd    : serial output, idle high
module uart_periph
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 5208,
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
    input  logic   clk,
    input  logic   reset,
    uart_if.slave  bus,
    input  logic   PC_Uart_rxd,
    output logic   PC_Uart_txd
);
    localparam logic [15:0] BIT_END = 16'(CLKS_PER_BIT - 1);

    logic        sel_txd, sel_rxd, sel_con;
    logic        txd_wr, con_wr, rxd_rd, con_rd;
    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d;
    logic        tx_busy, tx_done_set;
    logic        tx_irq_en_q, tx_irq_en_d, rx_irq_en_q, rx_irq_en_d;
    logic        tx_done_q, tx_done_d, rx_valid_q, rx_valid_d;
    logic        rx_overrun_q, rx_overrun_d, frame_err_q, frame_err_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        irq_q, irq_d;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid, rx_frame_err;
    logic [31:0] con_value;
    logic        unused_wdata;

    assign unused_wdata = ^bus.wdata[31:8];

    assign sel_txd = (bus.addr == BASE_ADDR + TXD_OFS);
    assign sel_rxd = (bus.addr == BASE_ADDR + RXD_OFS);
    assign sel_con = (bus.addr == BASE_ADDR + CON_OFS);
    assign txd_wr  = bus.wr & sel_txd;
    assign con_wr  = bus.wr & sel_con;
    assign rxd_rd  = bus.rd & sel_rxd;
    assign con_rd  = bus.rd & sel_con;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk           (clk),
        .reset         (reset),
        .rxd_async     (PC_Uart_rxd),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .rx_frame_err  (rx_frame_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q   <= T_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            txd_q        <= 1'b1;
            tx_irq_en_q  <= 1'b0;
            rx_irq_en_q  <= 1'b0;
            tx_done_q    <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_data_q    <= '0;
            irq_q        <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            txd_q        <= txd_d;
            tx_irq_en_q  <= tx_irq_en_d;
            rx_irq_en_q  <= rx_irq_en_d;
            tx_done_q    <= tx_done_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
            frame_err_q  <= frame_err_d;
            rx_data_q    <= rx_data_d;
            irq_q        <= irq_d;
        end
    end

    // The line level is registered and computed alongside the next state so
    // PC_Uart_txd changes exactly on the edge that enters each bit.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        txd_d       = txd_q;
        tx_done_set = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                if (txd_wr) begin
                    tx_shift_d = bus.wdata[7:0];
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    txd_d      = 1'b0;
                    tx_state_d = T_START;
                end
            end
            T_START: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    txd_d      = tx_shift_q[0];
                    tx_state_d = T_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            T_DATA: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        txd_d      = 1'b1;
                        tx_state_d = T_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            T_STOP: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d    = '0;
                    tx_state_d  = T_IDLE;
                    tx_done_set = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: begin
                tx_state_d = T_IDLE;
                txd_d      = 1'b1;
            end
        endcase
    end

    assign tx_busy = (tx_state_q != T_IDLE);

    // Clear-by-read is applied before the set terms so a same-cycle set wins.
    always_comb begin
        tx_irq_en_d  = tx_irq_en_q;
        rx_irq_en_d  = rx_irq_en_q;
        tx_done_d    = tx_done_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = rx_overrun_q;
        frame_err_d  = frame_err_q;
        rx_data_d    = rx_data_q;
        if (con_wr) begin
            tx_irq_en_d = bus.wdata[0];
            rx_irq_en_d = bus.wdata[1];
        end
        if (rxd_rd) begin
            rx_valid_d = 1'b0;
        end
        if (con_rd) begin
            tx_done_d    = 1'b0;
            rx_overrun_d = 1'b0;
            frame_err_d  = 1'b0;
        end
        if (tx_done_set) begin
            tx_done_d = 1'b1;
        end
        if (rx_byte_valid) begin
            rx_data_d  = rx_byte;
            rx_valid_d = 1'b1;
            if (rx_valid_q) begin
                rx_overrun_d = 1'b1;
            end
        end
        if (rx_frame_err) begin
            frame_err_d = 1'b1;
        end
        irq_d = (tx_irq_en_q & tx_done_q) | (rx_irq_en_q & rx_valid_q);
    end

    always_comb begin
        con_value                 = '0;
        con_value[CON_TX_IRQ_EN]  = tx_irq_en_q;
        con_value[CON_RX_IRQ_EN]  = rx_irq_en_q;
        con_value[CON_TX_DONE]    = tx_done_q;
        con_value[CON_RX_VALID]   = rx_valid_q;
        con_value[CON_TX_BUSY]    = tx_busy;
        con_value[CON_RX_OVERRUN] = rx_overrun_q;
        con_value[CON_FRAME_ERR]  = frame_err_q;
    end

    // TXD is write-only and reads back as zero
    always_comb begin
        bus.rdata = '0;
        if (bus.rd) begin
            if (sel_rxd) begin
                bus.rdata = {24'd0, rx_data_q};
            end else if (sel_con) begin
                bus.rdata = con_value;
            end
        end
    end

    assign PC_Uart_txd = txd_q;
    assign bus.irqout  = irq_q;

endmodule

// File: tb/tb_uart_periph.sv
// tb/tb_uart_periph.sv - self-checking bench for uart_periph with a frame-level reference model
module tb_uart_periph;
    localparam int          CPB  = 16;
    localparam int          FRM  = 10 * CPB;
    localparam logic [31:0] BASE = 32'h4000_0018;
    localparam logic [31:0] TXA  = BASE;
    localparam logic [31:0] RXA  = BASE + 32'd4;
    localparam logic [31:0] CONA = BASE + 32'd8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd = 1'b1;
    logic txd;
    uart_if bus_if ();

    uart_periph #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .bus         (bus_if),
        .PC_Uart_rxd (rxd),
        .PC_Uart_txd (txd)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model state: frame start edge, CON fields, RX data
    int         ecnt = 0;
    bit         m_started = 0;
    int         m_start = 0;
    logic [7:0] m_byte = 0;
    bit         m_txen = 0, m_rxen = 0, m_done = 0, m_rxv = 0, m_ovr = 0, m_ferr = 0;
    logic [7:0] m_rxdata = 0;
    bit         exp_txd = 1, exp_irq = 0;
    bit         rx_busy_tb = 0;
    bit         chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Line level k cycles into a frame: start 0, 8 data bits LSB first, stop 1
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        int idx;
        idx = k / CPB;
        if (idx == 0) return 1'b0;
        else if (idx <= 8) return b[idx-1];
        else return 1'b1;
    endfunction

    function automatic logic [31:0] model_con();
        bit busy;
        busy = m_started && ((ecnt - m_start) < FRM);
        return {25'd0, m_ferr, m_ovr, busy, m_rxv, m_done, m_rxen, m_txen};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecnt = 0; m_started = 0; m_start = 0;
            m_txen = 0; m_rxen = 0; m_done = 0; m_rxv = 0; m_ovr = 0; m_ferr = 0;
            m_rxdata = 0; exp_txd = 1; exp_irq = 0;
        end else begin
            bit busy_before, done_set, o_txen, o_done, o_rxen, o_rxv;
            ecnt++;
            o_txen = m_txen; o_done = m_done; o_rxen = m_rxen; o_rxv = m_rxv;
            busy_before = m_started && ((ecnt - m_start) <= FRM);
            done_set    = m_started && ((ecnt - m_start) == FRM);
            if (bus_if.wr && bus_if.addr == TXA && !busy_before) begin
                m_started = 1; m_start = ecnt; m_byte = bus_if.wdata[7:0];
            end
            if (bus_if.wr && bus_if.addr == CONA) begin
                m_txen = bus_if.wdata[0]; m_rxen = bus_if.wdata[1];
            end
            if (bus_if.rd && bus_if.addr == RXA) m_rxv = 0;
            if (bus_if.rd && bus_if.addr == CONA) begin
                m_done = 0; m_ovr = 0; m_ferr = 0;
            end
            if (done_set) m_done = 1;
            exp_irq = (o_txen & o_done) | (o_rxen & o_rxv);
            if (m_started && ((ecnt - m_start) < FRM)) exp_txd = frame_bit(m_byte, ecnt - m_start);
            else exp_txd = 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("txd_line", {31'd0, txd}, {31'd0, exp_txd});
            if (!rx_busy_tb) check("irqout", {31'd0, bus_if.irqout}, {31'd0, exp_irq});
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_if.wr = 1; bus_if.addr = a; bus_if.wdata = d;
        @(posedge clk);
        @(negedge clk);
        bus_if.wr = 0; bus_if.addr = 0; bus_if.wdata = 0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name);
        bus_if.rd = 1; bus_if.addr = a;
        #1;
        check(name, bus_if.rdata, exp);
        @(posedge clk);
        @(negedge clk);
        bus_if.rd = 0; bus_if.addr = 0;
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop);
        logic [9:0] frame;
        rx_busy_tb = 1;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = frame[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = 1;
        repeat (4) @(negedge clk);
        if (stop) begin
            if (m_rxv) m_ovr = 1;
            m_rxv = 1;
            m_rxdata = b;
        end else begin
            m_ferr = 1;
        end
        repeat (2) @(negedge clk);
        rx_busy_tb = 0;
    endtask

    initial begin
        logic [9:0] a5_bits;
        bus_if.rd = 0; bus_if.wr = 0; bus_if.addr = 0; bus_if.wdata = 0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_txd", {31'd0, txd}, 32'd1);
        check("reset_irq", {31'd0, bus_if.irqout}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        chk_en = 1;
        bus_if.addr = CONA;
        #1;
        check("rdata_no_rd", bus_if.rdata, 32'd0);
        bus_if.addr = 0;
        bus_read(CONA, 32'h0, "con_reset");
        bus_read(RXA, 32'h0, "rxd_reset");

        // A5 frame: literal bit pattern sampled mid-slot, then tx_done
        a5_bits = 10'b1101001010;
        bus_write(TXA, 32'hA5);
        for (int i = 0; i < 10; i++) begin
            repeat (8) @(negedge clk);
            check($sformatf("a5_bit%0d", i), {31'd0, txd}, {31'd0, a5_bits[i]});
            repeat (8) @(negedge clk);
        end
        bus_read(CONA, 32'h04, "con_txdone_a5");

        // CON read on the very edge tx_done sets
        bus_write(TXA, 32'h3C);
        repeat (FRM - 1) @(negedge clk);
        bus_read(CONA, 32'h10, "con_same_cycle");
        bus_read(CONA, 32'h04, "con_after_set");

        // RX with rx interrupt enabled
        bus_write(CONA, 32'h2);
        send_rx(8'h3C, 1);
        check("irq_rx_set", {31'd0, bus_if.irqout}, 32'd1);
        bus_read(RXA, 32'h3C, "rxd_3c");
        check("irq_hold", {31'd0, bus_if.irqout}, 32'd1);
        @(negedge clk);
        check("irq_clear", {31'd0, bus_if.irqout}, 32'd0);
        bus_read(CONA, 32'h02, "con_rxv_clear");

        // Overrun
        send_rx(8'h11, 1);
        send_rx(8'h22, 1);
        bus_read(RXA, 32'h22, "rxd_22");
        bus_read(CONA, 32'h22, "con_overrun");
        bus_read(CONA, 32'h02, "con_ovr_clear");

        // Glitch then bad stop bit
        rxd = 0;
        repeat (4) @(negedge clk);
        rxd = 1;
        repeat (200) @(negedge clk);
        bus_read(CONA, 32'h02, "con_glitch");
        send_rx(8'h5A, 0);
        bus_read(CONA, 32'h42, "con_frame_err");
        bus_read(RXA, 32'h22, "rxd_after_ferr");

        // Busy write ignored, then reset mid-frame
        bus_write(CONA, 32'h0);
        bus_write(TXA, 32'h55);
        repeat (39) @(negedge clk);
        bus_write(TXA, 32'hFF);
        repeat (19) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("rst_mid_txd", {31'd0, txd}, 32'd1);
        check("rst_mid_irq", {31'd0, bus_if.irqout}, 32'd0);
        bus_if.rd = 1; bus_if.addr = CONA;
        #1;
        check("rst_mid_con", bus_if.rdata, 32'd0);
        bus_if.rd = 0; bus_if.addr = 0;
        @(negedge clk);
        rst_n = 1;
        bus_read(CONA, 32'h0, "con_after_reset");
        bus_write(TXA, 32'hC3);
        repeat (FRM + 10) @(negedge clk);
        bus_read(CONA, model_con(), "con_fresh_frame");

        // Randomized traffic against the model
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 5))
                0: bus_write(TXA, $urandom);
                1: bus_write(CONA, 32'($urandom_range(0, 3)));
                2: bus_read(CONA, model_con(), "rnd_con");
                3: bus_read(RXA, {24'd0, m_rxdata}, "rnd_rxd");
                4: send_rx(8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
                default: repeat ($urandom_range(1, 60)) @(negedge clk);
            endcase
        end
        repeat (FRM + 10) @(negedge clk);
        bus_read(CONA, model_con(), "final_con");
        bus_read(RXA, {24'd0, m_rxdata}, "final_rxd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
